branch_predictor_gshare: RTL and testbench

//  Parametrised direction/target predictor for the pipelined core, split out of the core top.

---
 rtl/branch_predictor_gshare_if.sv | 36 +++
 rtl/branch_predictor_gshare.sv | 167 ++++++++++++++++
 tb/tb_branch_predictor_gshare.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_gshare_if.sv
// Fetch-lookup, execute-update and statistics signals between the core and the gshare predictor.
interface branch_predictor_gshare_if #(
   parameter int PC_W  = 32,
   parameter int GHR_W = 2
);
   logic             ready;
   logic             f_valid;
   logic [PC_W-1:0]  f_pc;
   logic             f_is_jump;
   logic             f_is_call;
   logic             f_is_ret;
   logic [PC_W-1:0]  f_next_pc;
   logic             f_pred_taken;
   logic [GHR_W-1:0] f_ghr;
   logic             u_valid;
   logic [PC_W-1:0]  u_pc;
   logic [GHR_W-1:0] u_ghr;
   logic             u_taken;
   logic [PC_W-1:0]  u_dest;
   logic             u_mispredict;
   logic [31:0]      perf_total;
   logic [31:0]      perf_hit;
   logic [31:0]      perf_miss;

   modport master (
      input  ready, f_next_pc, f_pred_taken, f_ghr, perf_total, perf_hit, perf_miss,
      output f_valid, f_pc, f_is_jump, f_is_call, f_is_ret,
             u_valid, u_pc, u_ghr, u_taken, u_dest, u_mispredict
   );

   modport slave (
      output ready, f_next_pc, f_pred_taken, f_ghr, perf_total, perf_hit, perf_miss,
      input  f_valid, f_pc, f_is_jump, f_is_call, f_is_ret,
             u_valid, u_pc, u_ghr, u_taken, u_dest, u_mispredict
   );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Gshare direction predictor with tagged BTB, init sweep, history repair and hit/miss counters.
// Optional return stack enabled by defining BP_RAS_EN.
module branch_predictor_gshare #(
  parameter int PC_W      = 32,
  parameter int IDX_W     = 8,
  parameter int GHR_W     = 2,
  parameter int CTR_W     = 2,
  parameter int CTR_INIT  = 1,
  parameter int RAS_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  branch_predictor_gshare_if.slave bp
);
  // state   | meaning
  // S_INIT  | sweeping one table row per cycle, lookups fall through, updates ignored
  // S_READY | normal lookup/update operation
  typedef enum logic {S_INIT, S_READY} state_t;

  localparam int ROWS    = 1 << IDX_W;
  localparam int CTRS    = 1 << GHR_W;
  localparam int TAG_W   = PC_W - IDX_W;
  localparam int CTR_MAX = (1 << CTR_W) - 1;

  state_t state, state_nx;
  logic [IDX_W-1:0] ptr;
  logic             ready;

  logic [CTR_W-1:0] pht [ROWS][CTRS];
  logic [ROWS-1:0]  btb_valid;
  logic [TAG_W-1:0] btb_tag [ROWS];
  logic [PC_W-1:0]  btb_tgt [ROWS];
  logic [GHR_W-1:0] ghr;
  logic [31:0]      perf_total, perf_hit, perf_miss;

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag;
  logic [CTR_W-1:0] f_ctr, u_ctr, u_ctr_nx;
  logic [PC_W-1:0]  fall_pc;
  logic             pht_taken, pred_taken;
  logic [PC_W-1:0]  next_pc;
  logic             upd_en;

  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:  if (ptr == IDX_W'(ROWS - 1)) state_nx = S_READY;
      S_READY: state_nx = S_READY;
      default: state_nx = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                 ptr <= '0;
    else if (state == S_INIT) ptr <= ptr + IDX_W'(1);
  end

  assign ready = (state == S_READY);

  // Lookup path: purely combinational, sees table contents before any same-cycle update.
  assign f_idx     = bp.f_pc[IDX_W-1:0];
  assign f_tag     = bp.f_pc[PC_W-1:IDX_W];
  assign f_ctr     = pht[f_idx][ghr];
  assign fall_pc   = bp.f_pc + PC_W'(1);
  assign pht_taken = ready && bp.f_is_jump && f_ctr[CTR_W-1] &&
                     btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);

`ifdef BP_RAS_EN
  localparam int RP_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int RD_W = $clog2(RAS_DEPTH + 1);

  logic [PC_W-1:0] ras [RAS_DEPTH];
  logic [RP_W-1:0] ras_sp, ras_top, ras_sp_inc;
  logic [RD_W-1:0] ras_depth;
  logic            ras_hit, ras_push, ras_pop;

  // ras_sp is the next slot to write; the top entry sits just below it, circularly.
  assign ras_top    = (ras_sp == '0) ? RP_W'(RAS_DEPTH - 1) : ras_sp - RP_W'(1);
  assign ras_sp_inc = (ras_sp == RP_W'(RAS_DEPTH - 1)) ? '0 : ras_sp + RP_W'(1);
  assign ras_hit    = ready && bp.f_valid && bp.f_is_ret && (ras_depth != '0);
  assign ras_push   = ready && bp.f_valid && bp.f_is_call;
  assign ras_pop    = ras_hit && !ras_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      ras_sp    <= '0;
      ras_depth <= '0;
    end else if (ras_push) begin
      ras_sp <= ras_sp_inc;
      if (ras_depth != RD_W'(RAS_DEPTH)) ras_depth <= ras_depth + RD_W'(1);
    end else if (ras_pop) begin
      ras_sp    <= ras_top;
      ras_depth <= ras_depth - RD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ras_push) ras[ras_sp] <= fall_pc;
  end

  assign pred_taken = pht_taken || ras_hit;
  assign next_pc    = ras_hit ? ras[ras_top] : (pht_taken ? btb_tgt[f_idx] : fall_pc);
`else
  logic unused_cfg;
  assign unused_cfg = bp.f_is_call ^ bp.f_is_ret ^ (RAS_DEPTH > 0);
  assign pred_taken = pht_taken;
  assign next_pc    = pht_taken ? btb_tgt[f_idx] : fall_pc;
`endif

  assign bp.f_next_pc    = next_pc;
  assign bp.f_pred_taken = pred_taken;
  assign bp.f_ghr        = ghr;
  assign bp.ready        = ready;
  assign bp.perf_total   = perf_total;
  assign bp.perf_hit     = perf_hit;
  assign bp.perf_miss    = perf_miss;

  assign upd_en = ready && !rst && bp.u_valid;
  assign u_idx  = bp.u_pc[IDX_W-1:0];
  assign u_ctr  = pht[u_idx][bp.u_ghr];

  always_comb begin
    u_ctr_nx = u_ctr;
    if (bp.u_taken) begin
      if (u_ctr != CTR_W'(CTR_MAX)) u_ctr_nx = u_ctr + CTR_W'(1);
    end else if (u_ctr != '0) begin
      u_ctr_nx = u_ctr - CTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == S_INIT) begin
      for (int g = 0; g < CTRS; g++) pht[ptr][g] <= CTR_W'(CTR_INIT);
      btb_valid[ptr] <= 1'b0;
    end else if (upd_en) begin
      pht[u_idx][bp.u_ghr] <= u_ctr_nx;
      if (bp.u_taken) begin
        btb_valid[u_idx] <= 1'b1;
        btb_tag[u_idx]   <= bp.u_pc[PC_W-1:IDX_W];
        btb_tgt[u_idx]   <= bp.u_dest;
      end
    end
  end

  // History repair from a resolved mispredict takes priority over the speculative shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr        <= '0;
      perf_total <= '0;
      perf_hit   <= '0;
      perf_miss  <= '0;
    end else if (ready) begin
      if (bp.u_valid && bp.u_mispredict) ghr <= {bp.u_ghr[GHR_W-2:0], bp.u_taken};
      else if (bp.f_valid && bp.f_is_jump) ghr <= {ghr[GHR_W-2:0], pred_taken};
      if (bp.u_valid) begin
        perf_total <= perf_total + 32'd1;
        if (bp.u_mispredict) perf_miss <= perf_miss + 32'd1;
        else                 perf_hit  <= perf_hit + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench for branch_predictor_gshare: init sweep, lookup, saturation, history repair, RAS.
module tb_branch_predictor_gshare;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cnt;

  branch_predictor_gshare_if #(.PC_W(32), .GHR_W(2)) bp ();

  branch_predictor_gshare dut (.clk(clk), .rst(rst), .bp(bp));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc, input logic jump);
    bp.f_pc      = pc;
    bp.f_is_jump = jump;
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [1:0] g, input logic tk,
                     input logic [31:0] dest, input logic misp);
    bp.u_pc = pc; bp.u_ghr = g; bp.u_taken = tk; bp.u_dest = dest; bp.u_mispredict = misp;
    bp.u_valid = 1'b1;
    tick();
    bp.u_valid = 1'b0;
  endtask

  task automatic wait_ready();
    cnt = 0;
    while (!bp.ready && cnt < 1000) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    bp.f_valid = 0; bp.f_pc = '0; bp.f_is_jump = 0; bp.f_is_call = 0; bp.f_is_ret = 0;
    bp.u_valid = 0; bp.u_pc = '0; bp.u_ghr = '0; bp.u_taken = 0; bp.u_dest = '0;
    bp.u_mispredict = 0;

    tick();
    rst = 1'b0;
    chk("ready_after_rst", {31'd0, bp.ready}, 32'd0);
    chk("perf_total_rst", bp.perf_total, 32'd0);
    chk("ghr_rst", {30'd0, bp.f_ghr}, 32'd0);
    wait_ready();
    chk("sweep_cycles", cnt, 32'd256);

    look(32'h5, 1'b0);
    chk("fall_5", bp.f_next_pc, 32'h6);
    chk("fall_5_tk", {31'd0, bp.f_pred_taken}, 32'd0);

    upd(32'h10, 2'b00, 1'b1, 32'h40, 1'b0);
    upd(32'h10, 2'b00, 1'b1, 32'h40, 1'b0);
    look(32'h10, 1'b1);
    chk("btb_hit_pc", bp.f_next_pc, 32'h40);
    chk("btb_hit_tk", {31'd0, bp.f_pred_taken}, 32'd1);
    look(32'h10, 1'b0);
    chk("not_jump", bp.f_next_pc, 32'h11);
    look(32'h110, 1'b1);
    chk("tag_alias", bp.f_next_pc, 32'h111);
    chk("perf_hit_2", bp.perf_hit, 32'd2);

    for (int i = 0; i < 5; i++) upd(32'h20, 2'b00, 1'b1, 32'h55, 1'b0);
    upd(32'h20, 2'b00, 1'b0, 32'h21, 1'b0);
    look(32'h20, 1'b1);
    chk("sat_hi_then_dec", bp.f_next_pc, 32'h55);
    upd(32'h20, 2'b00, 1'b0, 32'h21, 1'b0);
    look(32'h20, 1'b1);
    chk("weak_nt", bp.f_next_pc, 32'h21);

    upd(32'h30, 2'b00, 1'b0, 32'h31, 1'b0);
    upd(32'h30, 2'b00, 1'b0, 32'h31, 1'b0);
    upd(32'h30, 2'b00, 1'b1, 32'h77, 1'b0);
    look(32'h30, 1'b1);
    chk("sat_lo_nt", {31'd0, bp.f_pred_taken}, 32'd0);
    upd(32'h30, 2'b00, 1'b1, 32'h77, 1'b0);
    look(32'h30, 1'b1);
    chk("sat_lo_recover", bp.f_next_pc, 32'h77);
    chk("perf_total_13", bp.perf_total, 32'd13);

    // speculative shift of a predicted-taken jump
    bp.f_valid = 1'b1;
    look(32'h10, 1'b1);
    tick();
    bp.f_valid = 1'b0;
    chk("spec_ghr", {30'd0, bp.f_ghr}, 32'h1);
    look(32'h10, 1'b1);
    chk("ghr1_row", bp.f_next_pc, 32'h11);

    bp.f_valid = 1'b1;
    upd(32'h70, 2'b10, 1'b0, 32'h71, 1'b1);
    bp.f_valid = 1'b0;
    chk("repair_ghr", {30'd0, bp.f_ghr}, 32'h0);
    chk("perf_miss_1", bp.perf_miss, 32'd1);
    upd(32'h70, 2'b01, 1'b1, 32'h90, 1'b1);
    chk("repair_ghr_tk", {30'd0, bp.f_ghr}, 32'h3);
    chk("perf_hit_13", bp.perf_hit, 32'd13);

    // lookup and update on the same row in one cycle
    bp.u_pc = 32'h40; bp.u_ghr = 2'b11; bp.u_taken = 1'b1; bp.u_dest = 32'h99;
    bp.u_mispredict = 1'b0; bp.u_valid = 1'b1;
    look(32'h40, 1'b1);
    chk("same_cycle_pre", bp.f_next_pc, 32'h41);
    tick();
    bp.u_valid = 1'b0;
    #1;
    chk("same_cycle_post", bp.f_next_pc, 32'h99);

    look(32'hFFFF_FFFF, 1'b0);
    chk("pc_wrap", bp.f_next_pc, 32'h0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_ready", {31'd0, bp.ready}, 32'd0);
    chk("rst_perf", bp.perf_total, 32'd0);
    chk("rst_ghr", {30'd0, bp.f_ghr}, 32'h0);
    look(32'h10, 1'b1);
    chk("init_fall", bp.f_next_pc, 32'h11);
    upd(32'h10, 2'b00, 1'b1, 32'h40, 1'b1);
    chk("init_upd_ignored", bp.perf_total, 32'd0);
    for (int i = 0; i < 98; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready();
    chk("resweep_cycles", cnt, 32'd256);
    look(32'h10, 1'b1);
    chk("btb_cleared", bp.f_next_pc, 32'h11);

`ifdef BP_RAS_EN
    bp.f_valid = 1'b1; bp.f_is_jump = 1'b0;
    bp.f_is_call = 1'b1; bp.f_pc = 32'h20;
    tick();
    bp.f_is_call = 1'b0; bp.f_is_ret = 1'b1; bp.f_pc = 32'h80;
    #1;
    chk("ras_ret", bp.f_next_pc, 32'h21);
    chk("ras_ret_tk", {31'd0, bp.f_pred_taken}, 32'd1);
    tick();
    bp.f_is_ret = 1'b0; bp.f_is_call = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bp.f_pc = 32'h100 + i;
      tick();
    end
    bp.f_is_call = 1'b0; bp.f_is_ret = 1'b1; bp.f_pc = 32'h80;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ras_pop", bp.f_next_pc, 32'h105 - i);
      tick();
    end
    #1;
    chk("ras_empty", bp.f_next_pc, 32'h81);
    chk("ras_empty_tk", {31'd0, bp.f_pred_taken}, 32'd0);
    bp.f_is_ret = 1'b0; bp.f_valid = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
